// File: rtl/mem_bist_pkg.sv
// Shared types and the march pattern helper for the memory BIST master.
package mem_bist_pkg;

    localparam int unsigned PAT_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        P0_WR_UP,
        P1_RD_UP,
        P2_WR_DN,
        P3_RD_DN
    } phase_t;

    // seed ^ addr, optionally complemented; callers truncate to their word width
    function automatic logic [PAT_W-1:0] pat(
        input logic [PAT_W-1:0] addr,
        input logic [PAT_W-1:0] seed,
        input logic             invert
    );
        logic [PAT_W-1:0] p;
        p = seed ^ addr;
        return invert ? ~p : p;
    endfunction

    function automatic logic is_write(input phase_t ph);
        return (ph == P0_WR_UP) || (ph == P2_WR_DN);
    endfunction

    // The descending phases are also the ones that use the complemented pattern
    function automatic logic is_desc(input phase_t ph);
        return (ph == P2_WR_DN) || (ph == P3_RD_DN);
    endfunction

endpackage

// File: rtl/mem_bist_addr_seq.sv
// Phase and address sequencer: walks each phase up or down and reloads on phase change.
module mem_bist_addr_seq
    import mem_bist_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 advance,
    output phase_t               phase,
    output logic [ADDR_SIZE-1:0] addr,
    output phase_t               next_phase_c,
    output logic [ADDR_SIZE-1:0] next_addr_c,
    output logic                 final_c
);

    localparam logic [ADDR_SIZE-1:0] ADDR_MAX = '1;

    logic last_c;

    // Position after the current access; no wrap inside a phase
    always_comb begin
        last_c       = is_desc(phase) ? (addr == '0) : (addr == ADDR_MAX);
        final_c      = (phase == P3_RD_DN) && (addr == '0);
        next_phase_c = phase;
        next_addr_c  = addr;
        if (last_c) begin
            next_phase_c = phase_t'(2'(phase) + 2'd1);
            next_addr_c  = is_desc(next_phase_c) ? ADDR_MAX : '0;
        end else if (is_desc(phase)) begin
            next_addr_c = addr - ADDR_SIZE'(1);
        end else begin
            next_addr_c = addr + ADDR_SIZE'(1);
        end
    end

    // Sequencer state; load restarts at P0 address 0
    always_ff @(posedge clk) begin
        if (!rst || load) begin
            phase <= P0_WR_UP;
            addr  <= '0;
        end else if (advance) begin
            phase <= next_phase_c;
            addr  <= next_addr_c;
        end
    end

endmodule

// File: rtl/mem_bist_master.sv
// March-test BIST master driving a single-port valid/ready memory.
module mem_bist_master
    import mem_bist_pkg::*;
#(
    parameter int unsigned          DATA_SIZE = 8,
    parameter int unsigned          ADDR_SIZE = 4,
    parameter logic [DATA_SIZE-1:0] SEED      = 8'hA5,
    parameter int unsigned          TIMEOUT   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ADDR_SIZE+1:0]   err_count,
    output logic [ADDR_SIZE-1:0]   err_addr,
    output logic                   valid,
    output logic                   wr_rd,
    output logic [ADDR_SIZE-1:0]   addr,
    output logic [DATA_SIZE-1:0]   wdata,
    input  logic [DATA_SIZE-1:0]   rdata,
    input  logic                   ready
);

    localparam int unsigned ERR_W = ADDR_SIZE + 2;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t               state;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 err_seen;

    phase_t               seq_phase;
    phase_t               next_phase_c;
    logic [ADDR_SIZE-1:0] seq_addr;
    logic [ADDR_SIZE-1:0] next_addr_c;
    logic                 final_c;

    logic                 load_c;
    logic                 advance_c;
    logic                 timeout_c;
    logic                 exit_c;
    logic                 error_c;
    logic [DATA_SIZE-1:0] expect_c;
    logic [DATA_SIZE-1:0] next_wdata_c;
    logic [ERR_W-1:0]     err_count_inc_c;

    mem_bist_addr_seq #(
        .ADDR_SIZE (ADDR_SIZE)
    ) u_seq (
        .clk          (clk),
        .rst          (rst),
        .load         (load_c),
        .advance      (advance_c),
        .phase        (seq_phase),
        .addr         (seq_addr),
        .next_phase_c (next_phase_c),
        .next_addr_c  (next_addr_c),
        .final_c      (final_c)
    );

    // Access completion, compare and next-request data
    always_comb begin
        load_c          = ((state == IDLE) || (state == DONE)) && start;
        timeout_c       = (state == WAIT) && !ready && (wait_cnt == CNT_W'(TIMEOUT - 1));
        exit_c          = (state == WAIT) && (ready || timeout_c);
        advance_c       = exit_c && !final_c;
        expect_c        = DATA_SIZE'(pat(PAT_W'(seq_addr), PAT_W'(SEED), is_desc(seq_phase)));
        next_wdata_c    = DATA_SIZE'(pat(PAT_W'(next_addr_c), PAT_W'(SEED), is_desc(next_phase_c)));
        error_c         = exit_c && (timeout_c || (!wr_rd && (rdata != expect_c)));
        err_count_inc_c = (&err_count) ? err_count : err_count + ERR_W'(1);
    end

    // Control FSM with registered request and status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            err_seen  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            err_addr  <= '0;
            valid     <= 1'b0;
            wr_rd     <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= ISSUE;
                        wait_cnt  <= '0;
                        err_seen  <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        err_addr  <= '0;
                        valid     <= 1'b1;
                        wr_rd     <= 1'b1;
                        addr      <= '0;
                        wdata     <= DATA_SIZE'(pat(PAT_W'(0), PAT_W'(SEED), 1'b0));
                    end
                end
                ISSUE: begin
                    valid    <= 1'b0;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (!exit_c) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end else begin
                        if (error_c) begin
                            err_count <= err_count_inc_c;
                            if (!err_seen) begin
                                err_addr <= addr;
                                err_seen <= 1'b1;
                            end
                        end
                        if (final_c) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= !error_c && (err_count == '0);
                            wr_rd <= 1'b0;
                            addr  <= '0;
                            wdata <= '0;
                        end else begin
                            state <= ISSUE;
                            valid <= 1'b1;
                            wr_rd <= is_write(next_phase_c);
                            addr  <= next_addr_c;
                            wdata <= next_wdata_c;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
